egress_tlp_arb: RTL and testbench
=================================

# egress_tlp_arb

Packet-atomic arbiter that shares the single PCIe transmit AXI-stream between three TLP sources: completion (cpl), read request (rdreq) and write request (wrreq). It sits at the head of the egress path, mirroring the ingress split into three classes. It grants one source per TLP, holds the grant from sop to eop, and registers the output beat. It also keeps per-class transmitted-TLP counters.

## Interface
Parameters:
- DATA_W, 128, TLP beat width; equals `PCIE_DATA_WIDTH`.
- KEEP_W, DATA_W/8, byte-enable width; equals `PCIE_DATA_KW`.
- CPL_PRIO, 0, 1 = completions have strict priority over the round-robin; 0 = pure round-robin.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- s_cpl_tdata / s_rd_tdata / s_wr_tdata, input, DATA_W, source beat data.
- s_cpl_tkeep / s_rd_tkeep / s_wr_tkeep, input, KEEP_W, source byte enables.
- s_cpl_sop / s_rd_sop / s_wr_sop, input, 1, first beat of TLP.
- s_cpl_eop / s_rd_eop / s_wr_eop, input, 1, last beat of TLP.
- s_cpl_tvalid / s_rd_tvalid / s_wr_tvalid, input, 1, source beat valid.
- s_cpl_tready / s_rd_tready / s_wr_tready, output, 1, source beat accepted.
- m_axis_tx_tdata, output, DATA_W, granted beat data (registered).
- m_axis_tx_tkeep, output, KEEP_W, registered.
- m_axis_tx_sop / m_axis_tx_eop, output, 1, registered.
- m_axis_tx_tvalid, output, 1, registered.
- m_axis_tx_tready, input, 1, downstream ready.
- cnt_cpl / cnt_rd / cnt_wr, output, 16, TLPs fully transmitted per class; wrap at 0xFFFF→0.

## Operation
- Index order: 0 = cpl, 1 = rdreq, 2 = wrreq.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - A source requests when tvalid && sop.
  - If any source requests, the winner is latched into a one-hot grant and the FSM moves to BUSY.
  - No source is readied in IDLE. A valid beat without sop is not a request and stalls.
- Winner selection:
  - CPL_PRIO=1 and cpl requesting: cpl wins.
  - Otherwise the first requester found scanning upward from rr_ptr, with wrap-around (e.g. rr_ptr=2 scans 2,0,1).
- BUSY:
  - s_X_tready = gnt[X] && (!m_axis_tx_tvalid || m_axis_tx_tready). Non-granted sources see tready=0.
  - Each accepted beat (tvalid && tready) is copied into the output register.
  - Mid-packet sop is passed through unchanged and ignored by the FSM.
  - An accepted beat with eop returns the FSM to IDLE, sets rr_ptr to (winner+1) mod 3 and increments that class's counter.
  - Under CPL_PRIO=1, a cpl win also updates rr_ptr.
- Output register:
  - On an accepted input beat, load data/keep/sop/eop and set tvalid=1.
  - Otherwise, if m_axis_tx_tready, clear tvalid. Data fields hold their last value.
- Source tvalid deasserting mid-packet is legal: the grant is held and the output bubbles.
- Reset (asynchronous assert, any time including mid-packet):
  - FSM→IDLE, grant=0, rr_ptr=0.
  - Counters=0.
  - All s_*_tready=0.
  - m_axis_tx_tvalid/sop/eop=0, tdata=0, tkeep=0.
  - A partially sent TLP is abandoned; downstream must tolerate the truncation on reset.

## Timing
- Arbitration: request seen in IDLE at cycle N → grant registered at N+1 → first beat accepted at N+1 (if output free) → on m_axis at N+2.
- In-packet throughput: 1 beat/cycle while m_axis_tx_tready=1. There are no bubbles from the arbiter.
- Inter-packet gap: eop accepted at cycle M → IDLE at M+1 → next sop accepted at M+2 at the earliest. This is one idle input cycle per TLP.
- Counter update is visible the cycle after the eop beat is accepted at the input, not when it leaves the output.
- Backpressure: with m_axis_tx_tvalid=1 and m_axis_tx_tready=0, output fields are stable and the granted tready=0.
- A 1-beat TLP (sop && eop) is legal and takes grant plus one cycle.

## Test plan
- Single cpl 3-beat TLP (tdata 0x11..,0x22..,0x33.., m_tready=1): s_cpl_tready high for cycles 1–3 after the request. m_axis shows 3 beats with sop on the first and eop on the third. cnt_cpl=1, others 0.
- All three sources present 1-beat TLPs simultaneously and continuously, CPL_PRIO=0: output order cpl, rd, wr, cpl, rd, wr. rr_ptr sequence 1,2,0. Each counter is 2 after 6 TLPs.
- CPL_PRIO=1, all three continuously requesting: only cpl TLPs are transmitted. Then drop cpl: rd then wr follow, in order from rr_ptr.
- Backpressure: 4-beat wr TLP with m_axis_tx_tready toggling 1,0,0,1,1,0,1,1: every beat appears exactly once, in order. Output holds stable while tready=0, and s_wr_tready=0 in those cycles.
- Source gap: rd TLP with s_rd_tvalid low for 2 cycles mid-packet while cpl requests: grant stays on rd, no cpl beat is interleaved, and cpl is granted after the rd eop.
- Reset mid-packet: assert rst_n=0 on beat 2 of 4: all outputs are 0 immediately, counters are 0, and rr_ptr=0. After release, a new cpl TLP is transmitted normally with cnt_cpl=1.
- Counter wrap: preload via 65535 wr TLPs (or force): the next TLP makes cnt_wr=0.

Source files
------------

// File: rtl/egress_tlp_arb.sv
// Packet-atomic egress arbiter: shares one PCIe TX AXI-stream between the
// completion, read-request and write-request sources, one whole TLP per grant.
module egress_tlp_arb #(
  parameter int DATA_W   = 128,
  parameter int KEEP_W   = DATA_W / 8,
  parameter int CPL_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_cpl_tdata,
  input  logic [KEEP_W-1:0] s_cpl_tkeep,
  input  logic              s_cpl_sop,
  input  logic              s_cpl_eop,
  input  logic              s_cpl_tvalid,
  output logic              s_cpl_tready,
  input  logic [DATA_W-1:0] s_rd_tdata,
  input  logic [KEEP_W-1:0] s_rd_tkeep,
  input  logic              s_rd_sop,
  input  logic              s_rd_eop,
  input  logic              s_rd_tvalid,
  output logic              s_rd_tready,
  input  logic [DATA_W-1:0] s_wr_tdata,
  input  logic [KEEP_W-1:0] s_wr_tkeep,
  input  logic              s_wr_sop,
  input  logic              s_wr_eop,
  input  logic              s_wr_tvalid,
  output logic              s_wr_tready,
  output logic [DATA_W-1:0] m_axis_tx_tdata,
  output logic [KEEP_W-1:0] m_axis_tx_tkeep,
  output logic              m_axis_tx_sop,
  output logic              m_axis_tx_eop,
  output logic              m_axis_tx_tvalid,
  input  logic              m_axis_tx_tready,
  output logic [15:0]       cnt_cpl,
  output logic [15:0]       cnt_rd,
  output logic [15:0]       cnt_wr
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q;
  logic [2:0]          gnt_q;
  logic [1:0]          win_q;
  logic [1:0]          rr_ptr_q;
  logic [15:0]         cnt_cpl_q, cnt_rd_q, cnt_wr_q;
  logic [DATA_W-1:0]   m_tdata_q;
  logic [KEEP_W-1:0]   m_tkeep_q;
  logic                m_sop_q, m_eop_q, m_tvalid_q;

  logic [2:0]          vld, req, rdy;
  logic [1:0]          win_d;
  logic                out_free, acc;
  logic [DATA_W-1:0]   sel_data;
  logic [KEEP_W-1:0]   sel_keep;
  logic                sel_sop, sel_eop;

  // Strict cpl priority first, then the first requester at or above ptr, wrapping.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] p;
    int         j;
    p = ptr;
    if (CPL_PRIO != 0 && r[0]) begin
      p = 2'd0;
    end else begin
      for (int k = 2; k >= 0; k--) begin
        j = int'(ptr) + k;
        if (j >= 3) j = j - 3;
        if (r[j]) p = 2'(j);
      end
    end
    return p;
  endfunction

  assign vld      = {s_wr_tvalid, s_rd_tvalid, s_cpl_tvalid};
  assign req      = vld & {s_wr_sop, s_rd_sop, s_cpl_sop};
  assign win_d    = pick(req, rr_ptr_q);
  assign out_free = !m_tvalid_q || m_axis_tx_tready;
  assign rdy      = (state_q == BUSY && out_free) ? gnt_q : 3'b000;
  assign acc      = |(rdy & vld);

  assign s_cpl_tready = rdy[0];
  assign s_rd_tready  = rdy[1];
  assign s_wr_tready  = rdy[2];

  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    if (gnt_q[0]) begin
      sel_data = s_cpl_tdata; sel_keep = s_cpl_tkeep; sel_sop = s_cpl_sop; sel_eop = s_cpl_eop;
    end else if (gnt_q[1]) begin
      sel_data = s_rd_tdata;  sel_keep = s_rd_tkeep;  sel_sop = s_rd_sop;  sel_eop = s_rd_eop;
    end else if (gnt_q[2]) begin
      sel_data = s_wr_tdata;  sel_keep = s_wr_tkeep;  sel_sop = s_wr_sop;  sel_eop = s_wr_eop;
    end
  end

  // Grant is held from the sop request until the eop beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      win_q     <= '0;
      rr_ptr_q  <= '0;
      cnt_cpl_q <= '0;
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            win_q   <= win_d;
            gnt_q   <= 3'b001 << win_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (acc && sel_eop) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
            case (win_q)
              2'd0:    cnt_cpl_q <= cnt_cpl_q + 16'd1;
              2'd1:    cnt_rd_q  <= cnt_rd_q + 16'd1;
              default: cnt_wr_q  <= cnt_wr_q + 16'd1;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_sop_q    <= 1'b0;
      m_eop_q    <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else if (acc) begin
      m_tdata_q  <= sel_data;
      m_tkeep_q  <= sel_keep;
      m_sop_q    <= sel_sop;
      m_eop_q    <= sel_eop;
      m_tvalid_q <= 1'b1;
    end else if (m_axis_tx_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tx_tdata  = m_tdata_q;
  assign m_axis_tx_tkeep  = m_tkeep_q;
  assign m_axis_tx_sop    = m_sop_q;
  assign m_axis_tx_eop    = m_eop_q;
  assign m_axis_tx_tvalid = m_tvalid_q;
  assign cnt_cpl          = cnt_cpl_q;
  assign cnt_rd           = cnt_rd_q;
  assign cnt_wr           = cnt_wr_q;

endmodule

// File: tb/tb_egress_tlp_arb.sv
// Scoreboard bench for egress_tlp_arb: two instances (round-robin and cpl-priority)
// share the source drivers; a mux picks which one is observed.
module tb_egress_tlp_arb;
  localparam int DW = 128;
  localparam int KW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          s;
    logic          e;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data[3];
  logic [KW-1:0] s_keep[3];
  logic          s_sop[3], s_eop[3], s_vld[3];
  logic          m_rdy;
  logic          sel;

  wire [2:0]     rdy0, rdy1;
  wire [DW-1:0]  md0, md1;
  wire [KW-1:0]  mk0, mk1;
  wire           ms0, ms1, me0, me1, mv0, mv1;
  wire [15:0]    c0_cpl, c0_rd, c0_wr, c1_cpl, c1_rd, c1_wr;

  beat_t         mb;
  logic          mv;
  logic [2:0]    rdy;
  logic [15:0]   cnt[3];

  beat_t         srcq[3][$];
  beat_t         expq[$];
  logic          hold[3];
  int            ncmp = 0;
  int            nerr = 0;
  int            nout = 0;

  egress_tlp_arb #(.DATA_W(DW), .KEEP_W(KW), .CPL_PRIO(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_cpl_tdata(s_data[0]), .s_cpl_tkeep(s_keep[0]), .s_cpl_sop(s_sop[0]), .s_cpl_eop(s_eop[0]),
    .s_cpl_tvalid(s_vld[0]), .s_cpl_tready(rdy0[0]),
    .s_rd_tdata(s_data[1]), .s_rd_tkeep(s_keep[1]), .s_rd_sop(s_sop[1]), .s_rd_eop(s_eop[1]),
    .s_rd_tvalid(s_vld[1]), .s_rd_tready(rdy0[1]),
    .s_wr_tdata(s_data[2]), .s_wr_tkeep(s_keep[2]), .s_wr_sop(s_sop[2]), .s_wr_eop(s_eop[2]),
    .s_wr_tvalid(s_vld[2]), .s_wr_tready(rdy0[2]),
    .m_axis_tx_tdata(md0), .m_axis_tx_tkeep(mk0), .m_axis_tx_sop(ms0), .m_axis_tx_eop(me0),
    .m_axis_tx_tvalid(mv0), .m_axis_tx_tready(m_rdy),
    .cnt_cpl(c0_cpl), .cnt_rd(c0_rd), .cnt_wr(c0_wr)
  );

  egress_tlp_arb #(.DATA_W(DW), .KEEP_W(KW), .CPL_PRIO(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_cpl_tdata(s_data[0]), .s_cpl_tkeep(s_keep[0]), .s_cpl_sop(s_sop[0]), .s_cpl_eop(s_eop[0]),
    .s_cpl_tvalid(s_vld[0]), .s_cpl_tready(rdy1[0]),
    .s_rd_tdata(s_data[1]), .s_rd_tkeep(s_keep[1]), .s_rd_sop(s_sop[1]), .s_rd_eop(s_eop[1]),
    .s_rd_tvalid(s_vld[1]), .s_rd_tready(rdy1[1]),
    .s_wr_tdata(s_data[2]), .s_wr_tkeep(s_keep[2]), .s_wr_sop(s_sop[2]), .s_wr_eop(s_eop[2]),
    .s_wr_tvalid(s_vld[2]), .s_wr_tready(rdy1[2]),
    .m_axis_tx_tdata(md1), .m_axis_tx_tkeep(mk1), .m_axis_tx_sop(ms1), .m_axis_tx_eop(me1),
    .m_axis_tx_tvalid(mv1), .m_axis_tx_tready(m_rdy),
    .cnt_cpl(c1_cpl), .cnt_rd(c1_rd), .cnt_wr(c1_wr)
  );

  always_comb begin
    mb     = sel ? {md1, mk1, ms1, me1} : {md0, mk0, ms0, me0};
    mv     = sel ? mv1 : mv0;
    rdy    = sel ? rdy1 : rdy0;
    cnt[0] = sel ? c1_cpl : c0_cpl;
    cnt[1] = sel ? c1_rd  : c0_rd;
    cnt[2] = sel ? c1_wr  : c0_wr;
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mkb(input int src, input int tlp, input int idx, input int n);
    beat_t b;
    b.d = {8'(src + 1), 8'(tlp), 8'(idx), 104'h5A5A_0123_4567_89AB_CDEF_1357_9B};
    b.k = (idx == n - 1) ? 16'h0FFF : 16'hFFFF;
    b.s = (idx == 0);
    b.e = (idx == n - 1);
    return b;
  endfunction

  task automatic load(input int src, input int tlp, input int n);
    for (int i = 0; i < n; i++) srcq[src].push_back(mkb(src, tlp, i, n));
  endtask

  task automatic expect_tlp(input int src, input int tlp, input int n);
    for (int i = 0; i < n; i++) expq.push_back(mkb(src, tlp, i, n));
  endtask

  task automatic wait_drain(input int maxc);
    int c = 0;
    while ((expq.size() != 0 || srcq[0].size() != 0 || srcq[1].size() != 0 ||
            srcq[2].size() != 0) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) check("drain_timeout", 160'(expq.size()), 160'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      srcq[i].delete();
      hold[i] = 1'b0;
    end
    expq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush();
    m_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag, input int a, input int b, input int c);
    check({tag, "_cnt_cpl"}, 160'(cnt[0]), 160'(a));
    check({tag, "_cnt_rd"},  160'(cnt[1]), 160'(b));
    check({tag, "_cnt_wr"},  160'(cnt[2]), 160'(c));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tvalid"}, 160'(mv), 160'd0);
    check({tag, "_beat"},   160'(mb), 160'd0);
    check({tag, "_tready"}, 160'(rdy), 160'd0);
    check_counts(tag, 0, 0, 0);
  endtask

  // Source drivers: pop a beat once it was accepted, then present the next head.
  initial begin
    logic acc[3];
    for (int i = 0; i < 3; i++) begin
      s_vld[i] = 1'b0; s_data[i] = '0; s_keep[i] = '0; s_sop[i] = 1'b0; s_eop[i] = 1'b0;
      hold[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) acc[i] = s_vld[i] && rdy[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (acc[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
        if (srcq[i].size() != 0 && !hold[i]) begin
          s_data[i] = srcq[i][0].d;
          s_keep[i] = srcq[i][0].k;
          s_sop[i]  = srcq[i][0].s;
          s_eop[i]  = srcq[i][0].e;
          s_vld[i]  = 1'b1;
        end else begin
          s_vld[i] = 1'b0;
        end
      end
    end
  end

  // Output monitor: every transferred beat is popped off the expected queue.
  initial begin
    beat_t snap;
    logic  stall_prev;
    stall_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_prev) check("hold_stable", 160'(mb), 160'(snap));
        if (mv && !m_rdy) check("stall_src_tready", 160'(rdy), 160'd0);
        if (mv && m_rdy) begin
          if (expq.size() == 0) check("unexpected_beat", 160'(mb), 160'd0);
          else check("beat", 160'(mb), 160'(expq.pop_front()));
          nout++;
        end
        stall_prev = mv && !m_rdy;
        snap = mb;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    logic pat[8];
    int   c;
    sel   = 1'b0;
    m_rdy = 1'b1;
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single 3-beat completion
    load(0, 0, 3);
    expect_tlp(0, 0, 3);
    wait_drain(50);
    check_counts("single_cpl", 1, 0, 0);

    // Round-robin with all three sources continuously requesting
    do_reset();
    for (int t = 0; t < 2; t++)
      for (int s = 0; s < 3; s++) begin
        load(s, t, 1);
        expect_tlp(s, t, 1);
      end
    wait_drain(60);
    check_counts("rr", 2, 2, 2);

    // Strict completion priority
    do_reset();
    sel = 1'b1;
    for (int t = 0; t < 4; t++) begin
      load(0, t, 1);
      expect_tlp(0, t, 1);
    end
    load(1, 0, 1);
    load(2, 0, 1);
    expect_tlp(1, 0, 1);
    expect_tlp(2, 0, 1);
    wait_drain(60);
    check_counts("prio", 4, 1, 1);
    sel = 1'b0;

    // Downstream backpressure on a 4-beat write
    do_reset();
    load(2, 7, 4);
    expect_tlp(2, 7, 4);
    c = 0;
    while (!mv && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("bp_first_valid", 160'(mv), 160'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 m_rdy = pat[i];
    end
    @(posedge clk);
    #1 m_rdy = 1'b1;
    wait_drain(40);
    check_counts("bp", 0, 0, 1);

    // Source gap mid-packet with a competing completion
    do_reset();
    load(1, 3, 4);
    expect_tlp(1, 3, 4);
    c = 0;
    while (srcq[1].size() > 2 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("gap_progress", 160'(srcq[1].size() <= 2), 160'd1);
    hold[1] = 1'b1;
    load(0, 9, 1);
    expect_tlp(0, 9, 1);
    repeat (3) begin
      @(negedge clk);
      check("gap_cpl_tready", 160'(rdy[0]), 160'd0);
    end
    hold[1] = 1'b0;
    wait_drain(40);
    check_counts("gap", 1, 1, 0);

    // Asynchronous reset in the middle of a 4-beat completion
    do_reset();
    c = nout;
    load(0, 4, 4);
    expect_tlp(0, 4, 4);
    while (nout < c + 2 && c < 100000) begin
      @(negedge clk);
      if (nout == c + 0 && expq.size() == 0) c = 100000;
    end
    check("midrst_beats_out", 160'(nout - c), 160'd2);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(0, 5, 2);
    expect_tlp(0, 5, 2);
    wait_drain(40);
    check_counts("post_rst", 1, 0, 0);

    // Counter wrap on the write class
    do_reset();
    force dut0.cnt_wr_q = 16'hFFFF;
    @(negedge clk);
    release dut0.cnt_wr_q;
    @(negedge clk);
    check("wrap_preload", 160'(cnt[2]), 160'hFFFF);
    load(2, 1, 1);
    expect_tlp(2, 1, 1);
    wait_drain(40);
    check_counts("wrap", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
